// File: rtl/apb_uart_rx_slave.sv
// APB-attached 8N1 UART receiver. Bytes are readable one cycle after the stop-bit sample and are buffered in a DEPTH-entry FIFO.
// The APB side has zero wait states. A full FIFO drops the incoming byte and raises overrun; a read of RXDATA pops one byte per access.
module apb_uart_rx_slave #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 8
) (
    input  logic        pclk,
    input  logic        Reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [4:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    input  logic        rx,
    output logic        rx_irq
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_F_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic               rx_meta_q, rx_s_q;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               stop_smp, frame_ok, frame_bad, busy;

    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_F_W-1:0] count_q, count_d;
    logic               empty, full, push, pop;
    logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic               irq_en_q, irq_en_d;
    logic               access, access_q, acc_edge;
    logic               wr_status, wr_ctrl;
    logic [7:0]         head;
    logic [4:0]         count5;
    logic               unused_pwdata;

    always_ff @(posedge pclk or posedge Reset) begin
        if (Reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge pclk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                // Re-check the line mid start bit so short glitches are rejected.
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_M1) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stop_smp  = (state_q == STOP) && (clk_cnt_q == BIT_M1);
        frame_ok  = stop_smp & rx_s_q;
        frame_bad = stop_smp & ~rx_s_q;
        busy      = (state_q != IDLE);
    end

    assign access    = psel & penable;
    assign acc_edge  = access & ~access_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_F_W'(DEPTH));
    assign pop       = acc_edge & ~pwrite & (paddr == 5'h00) & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign push      = frame_ok & (~full | pop);
    assign wr_status = acc_edge & pwrite & (paddr == 5'h01);
    assign wr_ctrl   = acc_edge & pwrite & (paddr == 5'h02);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_F_W'(1);
            2'b01:   count_d = count_q - CNT_F_W'(1);
            default: count_d = count_q;
        endcase
        overrun_d   = (frame_ok & full & ~pop) | (overrun_q & ~(wr_status & pwdata[7]));
        frame_err_d = frame_bad | (frame_err_q & ~(wr_status & pwdata[8]));
        irq_en_d    = wr_ctrl ? pwdata[0] : irq_en_q;
    end

    always_ff @(posedge pclk or posedge Reset) begin
        if (Reset) begin
            access_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            irq_en_q    <= 1'b0;
        end else begin
            access_q    <= access;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            irq_en_q    <= irq_en_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    assign head   = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count5 = 5'(count_q);

    always_comb begin
        prdata = '0;
        if (psel) begin
            case (paddr)
                5'h00:   prdata = {24'b0, head};
                5'h01:   prdata = {22'b0, busy, frame_err_q, overrun_q, full, empty, count5};
                5'h02:   prdata = {31'b0, irq_en_q};
                default: prdata = '0;
            endcase
        end
    end

    assign pready = 1'b1;
    assign rx_irq = irq_en_q & (~empty | overrun_q | frame_err_q);

    assign unused_pwdata = ^{pwdata[31:9], pwdata[6:1]};
endmodule

// File: tb/tb_apb_uart_rx_slave.sv
// Bench for apb_uart_rx_slave: directed UART frames and APB accesses, read data checked by a scoreboard monitor.
module tb_apb_uart_rx_slave;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;

    logic        pclk = 1'b0;
    logic        Reset, psel, penable, pwrite, rx;
    logic [4:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, rx_irq;

    always #5 pclk = ~pclk;

    apb_uart_rx_slave #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .pclk(pclk), .Reset(Reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .rx(rx), .rx_irq(rx_irq)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        acc_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare read data on the first cycle of each read access.
    always @(negedge pclk) begin
        if (psel && penable && !acc_prev && !pwrite) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got 0x%0h, expected no access", prdata);
            end else begin
                check(tag_q.pop_front(), prdata, exp_q.pop_front());
            end
        end
        acc_prev <= psel && penable;
    end

    task automatic apb_read(input logic [4:0] a, input logic [31:0] e, input string t, input int hold = 1);
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge pclk); #1 psel = 1'b1; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1 penable = 1'b1;
        repeat (hold) @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge pclk); #1 psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(posedge pclk); #1 rx = 1'b0;
        repeat (CPB) @(posedge pclk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge pclk);
            #1;
        end
        rx = stop;
        repeat (CPB) @(posedge pclk);
        #1 rx = 1'b1;
        repeat (CPB) @(posedge pclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; rx = 1'b1;

        repeat (3) @(posedge pclk);
        #1;
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", {31'b0, pready}, 32'h1);
        check("rst_irq", {31'b0, rx_irq}, 32'h0);
        psel = 1'b1; paddr = 5'h01;
        #1 check("rst_status_comb", prdata, 32'h020);
        psel = 1'b0;
        Reset = 1'b0;

        apb_read(5'h01, 32'h020, "reset_status");
        apb_read(5'h05, 32'h0, "unmapped_read");
        apb_read(5'h02, 32'h0, "ctrl_reset");

        fork
            send_byte(8'hA5, 1'b1);
            begin
                repeat (60) @(posedge pclk);
                apb_read(5'h01, 32'h220, "busy_status");
            end
        join
        apb_read(5'h01, 32'h001, "a5_status");
        apb_read(5'h00, 32'h0A5, "a5_data");
        apb_read(5'h01, 32'h020, "a5_empty");
        apb_read(5'h00, 32'h0, "empty_read");

        send_byte(8'h3C, 1'b0);
        apb_read(5'h01, 32'h120, "fe_status");
        apb_write(5'h01, 32'h100);
        apb_read(5'h01, 32'h020, "fe_cleared");

        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b1);
        apb_read(5'h01, 32'h0C8, "ovf_status");
        for (int i = 0; i < DEPTH; i++) apb_read(5'h00, 32'(i), $sformatf("ovf_data%0d", i));
        apb_read(5'h01, 32'h0A0, "ovf_drained");
        apb_write(5'h01, 32'h080);
        apb_read(5'h01, 32'h020, "ovr_cleared");

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        apb_read(5'h00, 32'h011, "held_read", 3);
        apb_read(5'h01, 32'h001, "held_count");
        apb_read(5'h00, 32'h022, "held_second");

        apb_write(5'h02, 32'h1);
        apb_read(5'h02, 32'h1, "ctrl_readback");
        #1 check("irq_idle", {31'b0, rx_irq}, 32'h0);
        send_byte(8'h5A, 1'b1);
        #1 check("irq_set", {31'b0, rx_irq}, 32'h1);
        apb_read(5'h00, 32'h05A, "irq_data");
        @(posedge pclk); #1 check("irq_clear", {31'b0, rx_irq}, 32'h0);

        @(posedge pclk); #1 rx = 1'b0;
        repeat (2) @(posedge pclk);
        #1 rx = 1'b1;
        repeat (20) @(posedge pclk);
        apb_read(5'h01, 32'h020, "glitch_status");
        #1 check("glitch_irq", {31'b0, rx_irq}, 32'h0);

        @(posedge pclk); #1 rx = 1'b0;
        repeat (60) @(posedge pclk);
        #1 Reset = 1'b1; rx = 1'b1;
        repeat (2) @(posedge pclk);
        #1 Reset = 1'b0;
        repeat (20) @(posedge pclk);
        apb_read(5'h01, 32'h020, "midframe_rst_status");
        apb_read(5'h02, 32'h0, "midframe_rst_ctrl");

        repeat (2) @(posedge pclk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
